// File: rtl/mips_instr_mem_if.sv
// Fetch/load bundle for mips_instr_mem: the core fetches on pc/inst, the loader writes on load_*.
// Fetch is combinational; loads are sampled on the memory's clock.
interface mips_instr_mem_if #(
   parameter int ADDR_BITS = 8
);
   logic [31:0]          inst;
   logic [31:0]          pc;
   logic                 load_en;
   logic [ADDR_BITS-1:0] load_addr;
   logic [31:0]          load_data;

   modport master (
      input  inst,
      output pc,
      output load_en,
      output load_addr,
      output load_data
   );

   modport slave (
      output inst,
      input  pc,
      input  load_en,
      input  load_addr,
      input  load_data
   );
endinterface

// File: rtl/mips_instr_mem.sv
// Instruction ROM/RAM: combinational fetch by byte pc, clocked program-load writes, async reset
// restores the built-in program image. Zero fetch latency; no backpressure (always accepts).
module mips_instr_mem #(
   parameter int DEPTH     = 256,
   parameter int ADDR_BITS = 8
) (
   output logic [31:0]          inst,
   input  logic [31:0]          pc,
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load_en,
   input  logic [ADDR_BITS-1:0] load_addr,
   input  logic [31:0]          load_data
);

   logic [31:0]          mem_q [DEPTH];
   logic [31:0]          mem_d [DEPTH];
   logic [ADDR_BITS-1:0] fetch_idx;
   logic                 fetch_oor;

   function automatic logic [31:0] default_word(input int unsigned idx);
      case (idx)
         0:       default_word = 32'h2008_0005;
         1:       default_word = 32'h2009_0003;
         2:       default_word = 32'h0109_5020;
         3:       default_word = 32'hAC0A_0000;
         default: default_word = 32'h0000_0000;
      endcase
   endfunction

   // An X on load_en falls through the if as false, so it never writes.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (load_en) begin
         mem_d[load_addr] = load_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= default_word(i);
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   assign fetch_idx = pc[ADDR_BITS+1:2];
   assign fetch_oor = |(pc >> (ADDR_BITS + 2));

   always_comb begin
      inst = 32'h0000_0000;
      if (rst_n && !fetch_oor) begin
         inst = mem_q[fetch_idx];
      end
   end

endmodule

// File: tb/tb_mips_instr_mem.sv
// Directed bench for mips_instr_mem: default image, address decode, loads, reset behaviour.
module tb_mips_instr_mem;

   localparam int ADDR_BITS = 8;

   logic clk;
   logic rst_n;
   int   total_cnt;
   int   pass_cnt;

   mips_instr_mem_if #(.ADDR_BITS(ADDR_BITS)) bus ();

   mips_instr_mem #(.DEPTH(256), .ADDR_BITS(ADDR_BITS)) dut (
      .inst      (bus.inst),
      .pc        (bus.pc),
      .clk       (clk),
      .rst_n     (rst_n),
      .load_en   (bus.load_en),
      .load_addr (bus.load_addr),
      .load_data (bus.load_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] exp);
      total_cnt++;
      assert (bus.inst === exp) pass_cnt++;
      else $error("FAIL %s: inst=%h expected=%h", tag, bus.inst, exp);
   endtask

   task automatic load_word(input logic [ADDR_BITS-1:0] addr, input logic [31:0] data);
      @(negedge clk);
      bus.load_en   = 1'b1;
      bus.load_addr = addr;
      bus.load_data = data;
      @(posedge clk);
      #1;
      bus.load_en   = 1'b0;
   endtask

   initial begin
      total_cnt     = 0;
      pass_cnt      = 0;
      rst_n         = 1'b0;
      bus.pc        = 32'd0;
      bus.load_en   = 1'b0;
      bus.load_addr = '0;
      bus.load_data = 32'd0;

      #1;
      check("reset_pc0_nop", 32'h0000_0000);
      #20;
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      bus.pc = 32'd0;  #20; check("w0", 32'h2008_0005);
      bus.pc = 32'd4;  #20; check("w1", 32'h2009_0003);
      bus.pc = 32'd8;  #20; check("w2", 32'h0109_5020);
      bus.pc = 32'd12; #20; check("w3", 32'hAC0A_0000);
      bus.pc = 32'd16; #1;  check("w4_zero", 32'h0000_0000);

      bus.pc = 32'h0000_0006; #1; check("misalign6", 32'h2009_0003);
      bus.pc = 32'h0000_000B; #1; check("misalignB", 32'h0109_5020);
      bus.pc = 32'h0000_0400; #1; check("oor_400", 32'h0000_0000);
      bus.pc = 32'h8000_0000; #1; check("oor_msb", 32'h0000_0000);
      bus.pc = 32'h0000_0400; #1; check("oor_alias_w0", 32'h0000_0000);

      // Write to word 5; inst must not change until the edge lands.
      @(negedge clk);
      bus.pc        = 32'd20;
      bus.load_en   = 1'b1;
      bus.load_addr = 8'd5;
      bus.load_data = 32'hDEAD_BEEF;
      #1;
      check("no_bypass", 32'h0000_0000);
      @(posedge clk);
      #1;
      bus.load_en = 1'b0;
      check("load_w5", 32'hDEAD_BEEF);
      bus.pc = 32'd16; #1; check("w4_after_load", 32'h0000_0000);

      @(negedge clk);
      bus.load_en   = 1'bx;
      bus.load_addr = 8'd6;
      bus.load_data = 32'h1111_1111;
      @(posedge clk);
      #1;
      bus.load_en = 1'b0;
      bus.pc = 32'd24; #1; check("x_en_nowrite", 32'h0000_0000);

      @(negedge clk);
      bus.load_addr = 8'd7;
      bus.load_data = 32'h2222_2222;
      @(posedge clk);
      #1;
      bus.pc = 32'd28; #1; check("en0_nowrite", 32'h0000_0000);

      load_word(8'd255, 32'hCAFE_F00D);
      bus.pc = 32'h0000_03FC; #1; check("w255", 32'hCAFE_F00D);
      bus.pc = 32'h0000_03FF; #1; check("w255_mis", 32'hCAFE_F00D);
      bus.pc = 32'h0000_07FC; #1; check("w255_oor", 32'h0000_0000);

      load_word(8'd0, 32'h1234_5678);
      bus.pc = 32'd0; #1; check("w0_overwr", 32'h1234_5678);

      // Reset pulse entirely between clock edges.
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_low_nop", 32'h0000_0000);
      #1;
      rst_n = 1'b1;
      #1;
      check("rst_restore_w0", 32'h2008_0005);
      bus.pc = 32'd20; #1; check("rst_restore_w5", 32'h0000_0000);
      bus.pc = 32'h0000_03FC; #1; check("rst_restore_w255", 32'h0000_0000);

      // Load attempted while held in reset across an edge must be dropped.
      @(negedge clk);
      rst_n         = 1'b0;
      bus.load_en   = 1'b1;
      bus.load_addr = 8'd2;
      bus.load_data = 32'hFFFF_FFFF;
      @(posedge clk);
      @(negedge clk);
      bus.load_en = 1'b0;
      #1;
      rst_n = 1'b1;
      bus.pc = 32'd8; #1; check("rst_load_dropped", 32'h0109_5020);

      load_word(8'd2, 32'h0BAD_F00D);
      check("first_load_after_rst", 32'h0BAD_F00D);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/mips_instr_mem.md
MIPS_INSTR_MEM -- requirements
Module: mips_instr_mem

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning number of 32-bit instruction words.
REQ-002 The block SHALL have parameter ADDR_BITS, default 8, meaning word-address width; DEPTH SHALL equal 2**ADDR_BITS.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port clk  input  1  rising-edge clock for program-load writes.
REQ-005 Port rst_n  input  1  asynchronous active-low reset; restores the default program image.
REQ-006 Port inst  output  32  instruction word fetched at pc.
REQ-007 Port pc  input  32  byte address of the instruction to fetch.
REQ-008 Port load_en  input  1  program-load write enable, sampled on clk rising edge.
REQ-009 Port load_addr  input  ADDR_BITS  word address for a program-load write.
REQ-010 Port load_data  input  32  instruction word to write.
REQ-011 Positional declaration order SHALL be inst, pc, clk, rst_n, load_en, load_addr, load_data, so that two-port positional hookups (inst, pc) remain valid.

Function
REQ-012 Storage SHALL be DEPTH words of 32 bits, indexed by word address.
REQ-013 Fetch SHALL be combinational: inst reflects pc within the same delta cycle, with zero clock latency.
REQ-014 Word address SHALL be pc[ADDR_BITS+1:2]; pc[1:0] SHALL be ignored, so misaligned pc fetches the containing word.
REQ-015 If any bit of pc[31:ADDR_BITS+2] is 1, inst SHALL be 32'h00000000 (NOP).
REQ-016 While rst_n is low, inst SHALL be 32'h00000000 regardless of pc.
REQ-017 The default program image SHALL be: word0 = 32'h20080005 (addi $t0,$zero,5), word1 = 32'h20090003 (addi $t1,$zero,3), word2 = 32'h01095020 (add $t2,$t0,$t1), word3 = 32'hAC0A0000 (sw $t2,0($zero)); all other words = 32'h00000000.
REQ-018 On a clk rising edge with rst_n high and load_en high, the block SHALL write load_data to word load_addr.
REQ-019 A word written on an edge SHALL be visible on inst immediately after that edge when pc addresses it; there is no read-during-write bypass before the edge.
REQ-020 With load_en low, memory contents SHALL remain unchanged.
REQ-021 X/Z on load_en SHALL be treated as no write.

Reset
REQ-022 Assertion of rst_n low SHALL immediately and asynchronously restore every word to the default image (REQ-017), independent of clk.
REQ-023 A load_en write coinciding with rst_n low SHALL be discarded.
REQ-024 After rst_n deasserts, fetch SHALL resume combinationally; the first write is permitted on the first clk rising edge with rst_n high.
REQ-025 No initialization other than rst_n SHALL be required for correct fetch of the default image at power-up, provided rst_n is pulsed low.

Verification
REQ-026 Reset pulse, then pc = 0, 4, 8, 12 held 20 time units each -> inst = 20080005, 20090003, 01095020, AC0A0000 in that order.
REQ-027 pc = 32'h00000006 -> inst = 20090003 (word 1, low bits ignored); pc = 32'h00000400 -> inst = 00000000 (out of range).
REQ-028 load_en = 1, load_addr = 5, load_data = DEADBEEF, one clk edge; then pc = 20 -> inst = DEADBEEF; pc = 16 -> inst = 00000000.
REQ-029 Overwrite word 0 with 12345678; then pulse rst_n low without a clk edge -> inst at pc = 0 returns to 20080005, and inst reads 00000000 while rst_n is low.
REQ-030 load_en = 1 with rst_n low across a clk edge (load_addr = 2, load_data = FFFFFFFF) -> after release, pc = 8 -> inst = 01095020.
